// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: 720p geometry, RGB565 pixel type and the
// packer state encoding.
package fb_pkg;

    localparam int H_ACTIVE_720P   = 1280;
    localparam int V_ACTIVE_720P   = 720;
    localparam int PIXEL_WIDTH_565 = 16;

    typedef logic [PIXEL_WIDTH_565-1:0] rgb565_t;

    // EMPTY: accumulator holds no pixels; FILLING: at least one lane written.
    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } packer_state_t;

endpackage

// File: rtl/frame_index_calc.sv
// Combinational (h, v) -> (word address, lane, in-range, final-pixel) mapping.
// The linear index is formed at 32 bits and then truncated to
// ADDR_WIDTH + LANE_BITS bits before being split into address and lane.
module frame_index_calc #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int ADDR_WIDTH = 24,
    parameter int LANE_BITS  = 3
) (
    input  logic [10:0]           h,
    input  logic [9:0]            v,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [LANE_BITS-1:0]  lane,
    output logic                  in_range,
    output logic                  is_last
);

    localparam int          IDX_W    = ADDR_WIDTH + LANE_BITS;
    localparam logic [31:0] LAST_IDX = 32'(H_ACTIVE * V_ACTIVE - 1);

    logic [31:0]      idx_full;
    logic [IDX_W-1:0] idx;

    // Linear index, its split into address/lane, and range/final classification.
    always_comb begin
        idx_full = 32'(v) * 32'(H_ACTIVE) + 32'(h);
        idx      = idx_full[IDX_W-1:0];
        lane     = idx[LANE_BITS-1:0];
        waddr    = idx[IDX_W-1:LANE_BITS];
        in_range = (32'(h) < 32'(H_ACTIVE)) && (32'(v) < 32'(V_ACTIVE));
        is_last  = in_range && (idx_full == LAST_IDX);
    end

endmodule

// File: rtl/frame_word_packer.sv
// Packs a possibly sparse, non-raster pixel stream into wide frame-buffer
// words carrying a word address and a lane mask. A partial word is flushed
// when the address changes or after FLUSH_IDLE_CYCLES idle cycles.
// Optional macro FRAME_WORD_PACKER_DROP_COUNT_EN enables the saturating
// dropped-pixel counter; without it drop_count is tied to zero.
//
// Handshakes: a pixel transfers on a rising clk edge where pixel_valid and
// pixel_ready are both high; an output word transfers on an edge where
// m_axis_tvalid and m_axis_tready are both high. While m_axis_tvalid is high
// and m_axis_tready is low, all m_axis_* outputs hold steady.
module frame_word_packer
    import fb_pkg::*;
#(
    parameter int PIXEL_WIDTH       = 16,
    parameter int WORD_WIDTH        = 128,
    parameter int H_ACTIVE          = 1280,
    parameter int V_ACTIVE          = 720,
    parameter int ADDR_WIDTH        = 24,
    parameter int FLUSH_IDLE_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    input  logic [PIXEL_WIDTH-1:0]            pixel_data,
    input  logic [10:0]                       pixel_h,
    input  logic [9:0]                        pixel_v,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [WORD_WIDTH-1:0]             m_axis_tdata,
    output logic [WORD_WIDTH/PIXEL_WIDTH-1:0] m_axis_tstrb,
    output logic [ADDR_WIDTH-1:0]             m_axis_taddr,
    output logic                              m_axis_tlast,
    output logic [15:0]                       drop_count
);

    localparam int PPW       = WORD_WIDTH / PIXEL_WIDTH;
    localparam int LANE_BITS = $clog2(PPW);
    localparam int IDLE_W    = (FLUSH_IDLE_CYCLES > 0) ? $clog2(FLUSH_IDLE_CYCLES + 1) : 1;

    packer_state_t state, state_next;

    logic [WORD_WIDTH-1:0] acc_data;
    logic [PPW-1:0]        acc_mask;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_last;
    logic                  acc_busy;
    logic [IDLE_W-1:0]     idle_cnt;

    logic [ADDR_WIDTH-1:0] pix_waddr;
    logic [LANE_BITS-1:0]  pix_lane;
    logic                  pix_in_range;
    logic                  pix_is_last;

    logic                  slot_free, accept, take, same_word, timeout;
    logic                  load_new, merge, full, flush_old;
    logic [PPW-1:0]        lane_bit, merge_mask;
    logic [WORD_WIDTH-1:0] load_data, merge_data;
    logic                  merge_last;

    frame_index_calc #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_BITS  (LANE_BITS)
    ) u_index (
        .h        (pixel_h),
        .v        (pixel_v),
        .waddr    (pix_waddr),
        .lane     (pix_lane),
        .in_range (pix_in_range),
        .is_last  (pix_is_last)
    );

    assign acc_busy = (state == ST_FILLING);
    assign timeout  = (FLUSH_IDLE_CYCLES != 0) && (idle_cnt == IDLE_W'(FLUSH_IDLE_CYCLES));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_next;
    end

    // Next state: completion empties, a fresh load fills, a timeout flush empties.
    always_comb begin
        state_next = state;
        if (full)           state_next = ST_EMPTY;
        else if (load_new)  state_next = ST_FILLING;
        else if (flush_old) state_next = ST_EMPTY;
    end

    // Control decode: ready, pixel classification and the flush/load strobes.
    always_comb begin
        slot_free   = !m_axis_tvalid || m_axis_tready;
        pixel_ready = !rst && (slot_free || state == ST_EMPTY);
        accept      = pixel_valid && pixel_ready;
        take        = accept && pix_in_range;
        same_word   = acc_busy && (pix_waddr == acc_addr);
        lane_bit    = PPW'(1) << pix_lane;

        load_data = '0;
        load_data[int'(pix_lane)*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data;
        merge_data = acc_data;
        merge_data[int'(pix_lane)*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data;
        merge_mask = acc_mask | lane_bit;
        merge_last = acc_last | pix_is_last;

        load_new  = take && !same_word;
        merge     = take && same_word;
        full      = merge && (&merge_mask);
        flush_old = acc_busy && ((take && !same_word) || (!take && timeout && slot_free));
    end

    // Accumulator: load a new word, merge into the current one, or clear on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_data <= '0;
            acc_mask <= '0;
            acc_addr <= '0;
            acc_last <= 1'b0;
        end else if (load_new) begin
            acc_data <= load_data;
            acc_mask <= lane_bit;
            acc_addr <= pix_waddr;
            acc_last <= pix_is_last;
        end else if (merge) begin
            acc_data <= merge_data;
            acc_mask <= full ? '0 : merge_mask;
            acc_last <= full ? 1'b0 : merge_last;
        end else if (flush_old) begin
            acc_mask <= '0;
            acc_last <= 1'b0;
        end
    end

    // Idle counter: cleared by in-range traffic or when empty, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (take || !acc_busy || flush_old) begin
            idle_cnt <= '0;
        end else if (!timeout && FLUSH_IDLE_CYCLES != 0) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Output register: loads on completion or flush, clears valid after handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_taddr  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (full) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= merge_data;
            m_axis_tstrb  <= merge_mask;
            m_axis_taddr  <= acc_addr;
            m_axis_tlast  <= merge_last;
        end else if (flush_old) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc_data;
            m_axis_tstrb  <= acc_mask;
            m_axis_taddr  <= acc_addr;
            m_axis_tlast  <= acc_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef FRAME_WORD_PACKER_DROP_COUNT_EN
    // Saturating count of discarded out-of-range pixels and stalled valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (((accept && !pix_in_range) || (pixel_valid && !pixel_ready))
                     && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_frame_word_packer.sv
// Bench for frame_word_packer: directed cases plus randomized sparse traffic,
// checked by a scoreboard fed from a word-level reference model.
module tb_frame_word_packer;
  import fb_pkg::*;

  localparam int PW = 16;
  localparam int WW = 128;
  localparam int PPW = WW / PW;
  localparam int AW = 24;
  localparam int HA = 1280;
  localparam int VA = 720;
  localparam int EXP_W = 1 + AW + PPW + WW;

  logic clk = 0;
  logic rst = 1;
  logic pixel_valid = 0;
  logic pixel_ready;
  rgb565_t pixel_data = '0;
  logic [10:0] pixel_h = '0;
  logic [9:0] pixel_v = '0;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [WW-1:0] m_axis_tdata;
  logic [PPW-1:0] m_axis_tstrb;
  logic [AW-1:0] m_axis_taddr;
  logic m_axis_tlast;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;
  int words_seen = 0;
  int bp_mode = 0;

  logic [EXP_W-1:0] exp_q[$];

  // reference model: one sparse word under construction
  bit m_has = 0;
  int m_addr = 0;
  rgb565_t m_lane[PPW];
  bit [PPW-1:0] m_mask = '0;
  bit m_last = 0;

  frame_word_packer #(
    .PIXEL_WIDTH(PW), .WORD_WIDTH(WW), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .ADDR_WIDTH(AW), .FLUSH_IDLE_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_data(pixel_data), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_taddr(m_axis_taddr), .m_axis_tlast(m_axis_tlast),
    .drop_count(drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_emit();
    logic [WW-1:0] d;
    d = '0;
    for (int k = 0; k < PPW; k++)
      if (m_mask[k]) d[k*PW +: PW] = m_lane[k];
    exp_q.push_back({m_last, AW'(m_addr), m_mask, d});
    m_has = 0;
    m_mask = '0;
    m_last = 0;
  endfunction

  function automatic void model_pixel(input int h, input int v, input rgb565_t d);
    int idx, a, l;
    if (h >= HA || v >= VA) return;
    idx = v * HA + h;
    a = idx / PPW;
    l = idx % PPW;
    if (m_has && a != m_addr) model_emit();
    if (!m_has) begin
      m_has = 1;
      m_addr = a;
    end
    m_lane[l] = d;
    m_mask[l] = 1'b1;
    if (idx == HA * VA - 1) m_last = 1;
    if (m_mask == '1) model_emit();
  endfunction

  function automatic void model_idle_flush();
    if (m_has) model_emit();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_has = 0;
    m_mask = '0;
    m_last = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // all called at posedge+1 and return at posedge+1
  task automatic send_pixel(input int h, input int v, input rgb565_t d);
    int waited;
    bit got;
    waited = 0;
    got = 0;
    pixel_valid = 1;
    pixel_h = 11'(h);
    pixel_v = 10'(v);
    pixel_data = d;
    while (!got && waited < 2000) begin
      @(negedge clk);
      if (pixel_ready) got = 1;
      else waited++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL pixel_accept_timeout h=%0d v=%0d never accepted, required acceptance", h, v);
      @(posedge clk); #1;
      pixel_valid = 0;
      return;
    end
    @(posedge clk); #1;
    pixel_valid = 0;
    model_pixel(h, v, d);
  endtask

  task automatic idle(input int n);
    model_idle_flush();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    @(negedge clk);
    check("rst_pixel_ready", 128'(pixel_ready), 128'(0));
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata", m_axis_tdata, 128'(0));
    check("rst_tstrb", 128'(m_axis_tstrb), 128'(0));
    check("rst_taddr", 128'(m_axis_taddr), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_drop_count", 128'(drop_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  // downstream ready pattern: 0 always ready, 1 random, 2 stalled
  initial begin
    m_axis_tready = 1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: m_axis_tready = 1;
        1: m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit prev_stall;
    logic [WW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [PPW-1:0] prev_strb;
    logic [EXP_W-1:0] e;
    logic [WW-1:0] lane_m;
    prev_stall = 0;
    prev_data = '0;
    prev_addr = '0;
    prev_strb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_tvalid", 128'(m_axis_tvalid), 128'(1));
          check("hold_tdata", m_axis_tdata, prev_data);
          check("hold_taddr", 128'(m_axis_taddr), 128'(prev_addr));
          check("hold_tstrb", 128'(m_axis_tstrb), 128'(prev_strb));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word taddr=%0d tstrb=%0h, required no word", m_axis_taddr, m_axis_tstrb);
          end else begin
            e = exp_q.pop_front();
            lane_m = '0;
            for (int k = 0; k < PPW; k++)
              if (e[WW+k]) lane_m[k*PW +: PW] = '1;
            check("word_taddr", 128'(m_axis_taddr), 128'(e[WW+PPW +: AW]));
            check("word_tstrb", 128'(m_axis_tstrb), 128'(e[WW +: PPW]));
            check("word_tlast", 128'(m_axis_tlast), 128'(e[EXP_W-1]));
            check("word_tdata", m_axis_tdata & lane_m, e[WW-1:0]);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_addr = m_axis_taddr;
        prev_strb = m_axis_tstrb;
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog simulation time limit reached before completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, h, v, base_h, base_v, seen0, waited;
    logic [WW-1:0] held;
    @(posedge clk); #1;
    do_reset();

    // raster row 0, one full word, 1-cycle latency
    for (int k = 0; k < 7; k++) send_pixel(k, 0, rgb565_t'(k + 1));
    check("raster_no_early_tvalid", 128'(m_axis_tvalid), 128'(0));
    send_pixel(7, 0, 16'h0008);
    @(negedge clk);
    check("raster_latency_tvalid", 128'(m_axis_tvalid), 128'(1));
    check("raster_tstrb", 128'(m_axis_tstrb), 128'h00FF);
    check("raster_lane0", 128'(m_axis_tdata[15:0]), 128'h0001);
    check("raster_lane7", 128'(m_axis_tdata[127:112]), 128'h0008);
    @(posedge clk); #1;

    // address-change flush then idle-timeout flush
    send_pixel(3, 0, 16'h1234);
    send_pixel(12, 0, 16'h4321);
    idle(100);

    // backpressure: stalled word, blocked second flush, then release
    bp_mode = 2;
    @(posedge clk); #1;
    for (int k = 16; k < 24; k++) send_pixel(k, 0, rgb565_t'($urandom));
    send_pixel(24, 0, 16'hBEEF);
    pixel_valid = 1;
    pixel_h = 11'd32;
    pixel_v = 10'd0;
    pixel_data = 16'hCAFE;
    @(negedge clk);
    held = m_axis_tdata;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_pixel_ready", 128'(pixel_ready), 128'(0));
      check("bp_taddr_stable", 128'(m_axis_taddr), 128'(2));
      check("bp_tdata_stable", m_axis_tdata, held);
    end
    @(posedge clk); #1;
    bp_mode = 0;
    send_pixel(32, 0, 16'hCAFE);
    idle(100);

    // out-of-range pixel, then final frame pixel alone
    do_reset();
    seen0 = words_seen;
    send_pixel(1280, 0, 16'h7777);
    repeat (3) @(posedge clk);
    #1;
`ifdef FRAME_WORD_PACKER_DROP_COUNT_EN
    check("drop_count_oob", 128'(drop_count), 128'(1));
`else
    check("drop_count_oob", 128'(drop_count), 128'(0));
`endif
    check("oob_no_word", 128'(words_seen - seen0), 128'(0));
    send_pixel(1279, 719, 16'h0F0F);
    idle(100);
    check("last_word_seen", 128'(words_seen - seen0), 128'(1));

    // duplicate lane, last write wins
    send_pixel(8, 5, 16'hAAAA);
    send_pixel(8, 5, 16'h5555);
    for (int k = 9; k < 16; k++) send_pixel(k, 5, rgb565_t'($urandom));
    idle(10);

    // reset with a stalled output word and a partial word pending
    bp_mode = 2;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) send_pixel(k, 11, rgb565_t'($urandom));
    send_pixel(0, 10, 16'h1111);
    do_reset();
    bp_mode = 0;
    seen0 = words_seen;
    idle(150);
    check("post_reset_no_word", 128'(words_seen - seen0), 128'(0));

    // randomized sparse traffic with random backpressure
    bp_mode = 1;
    base_h = 0;
    base_v = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        h = base_h + $urandom_range(0, 15);
        v = base_v;
      end else if (r < 88) begin
        base_h = $urandom_range(0, 1272);
        base_v = $urandom_range(0, 719);
        h = base_h;
        v = base_v;
      end else if (r < 96) begin
        h = $urandom_range(1270, 1300);
        v = $urandom_range(700, 725);
      end else begin
        h = 1279;
        v = 719;
      end
      send_pixel(h, v, rgb565_t'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (n % 97 == 50) idle(150);
    end
    idle(200);
    bp_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
